muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// FSM state encoding, op/read select constants and the divide-by-zero LO value.
package muldiv_sequencer_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step on
// {hi,lo} (multiplier in lo) or a restoring-divide step (dividend shifting out of lo).
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi_nx_c,
    output logic [WIDTH-1:0] lo_nx_c
);

    logic [WIDTH:0] sum_c;
    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] diff_c;

    // Single add/subtract-shift step; diff sign bit decides the quotient bit.
    always_comb begin
        sum_c     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, divisor} : '0);
        shifted_c = {hi_in, lo_in[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, divisor};
        hi_nx_c   = hi_in;
        lo_nx_c   = lo_in;
        if (op == OP_MUL) begin
            hi_nx_c = sum_c[WIDTH:1];
            lo_nx_c = {sum_c[0], lo_in[WIDTH-1:1]};
        end else if (!diff_c[WIDTH]) begin
            hi_nx_c = diff_c[WIDTH-1:0];
            lo_nx_c = {lo_in[WIDTH-2:0], 1'b1};
        end else begin
            hi_nx_c = shifted_c[WIDTH-1:0];
            lo_nx_c = {lo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit with pipeline stall generation.
// Optional build macro MULDIV_SIGNED_EN adds the signed_op port and the FIX
// state that applies sign correction (mult/div vs multu/divu).
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mul0_div1_sel,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hilo_rd,
    input  logic             hi0_lo1_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           state_nx;
    logic             busy_nx;
    logic             done_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] divisor_q;
    logic             op_q;
    logic             div0_q;
    logic [WIDTH-1:0] step_hi_c;
    logic [WIDTH-1:0] step_lo_c;
    logic [WIDTH-1:0] a_load_c;
    logic [WIDTH-1:0] b_load_c;
    logic             accept_c;
    logic             fix_c;
`ifdef MULDIV_SIGNED_EN
    logic             neg_lo_c;
    logic             neg_hi_c;
    logic             neg_lo_q;
    logic             neg_hi_q;
`endif

    assign accept_c = start & ~busy;

    // Pipeline freeze: hold reads until the result lands, hold a second issue while running.
    assign stall = (hilo_rd & (busy | start | (state == DONE))) | (start & busy);

    // Architectural HI/LO read port.
    assign hilo_out = (hi0_lo1_sel == SEL_HI) ? hi_q : lo_q;

`ifdef MULDIV_SIGNED_EN
    assign fix_c = neg_lo_q | neg_hi_q;
`else
    assign fix_c = 1'b0;
`endif

    // Operand conditioning: magnitudes for signed ops, raw bits otherwise (and for /0).
    always_comb begin
        a_load_c = opa;
        b_load_c = opb;
`ifdef MULDIV_SIGNED_EN
        neg_lo_c = 1'b0;
        neg_hi_c = 1'b0;
        if (signed_op) begin
            if (mul0_div1_sel == OP_MUL) begin
                neg_lo_c = opa[WIDTH-1] ^ opb[WIDTH-1];
                neg_hi_c = opa[WIDTH-1] ^ opb[WIDTH-1];
                a_load_c = opa[WIDTH-1] ? -opa : opa;
                b_load_c = opb[WIDTH-1] ? -opb : opb;
            end else if (opb != '0) begin
                neg_lo_c = opa[WIDTH-1] ^ opb[WIDTH-1];
                neg_hi_c = opa[WIDTH-1];
                a_load_c = opa[WIDTH-1] ? -opa : opa;
                b_load_c = opb[WIDTH-1] ? -opb : opb;
            end
        end
`endif
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (op_q),
        .hi_in   (acc_hi),
        .lo_in   (acc_lo),
        .divisor (divisor_q),
        .hi_nx_c (step_hi_c),
        .lo_nx_c (step_lo_c)
    );

    // State register with registered busy/done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next-state and flag decode; DONE may chain straight into a new RUN.
    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) state_nx = RUN;
            end
            RUN: begin
                if (cnt == '0) state_nx = fix_c ? FIX : DONE;
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
                state_nx = DONE;
            end
`endif
            DONE: begin
                state_nx = accept_c ? RUN : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx == RUN) || (state_nx == FIX);
        done_nx = (state == DONE);
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            divisor_q <= '0;
            op_q      <= OP_MUL;
            div0_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        hi_q <= acc_hi;
                        lo_q <= div0_q ? DIV0_LO[WIDTH-1:0] : acc_lo;
                    end
                    if (accept_c) begin
                        cnt       <= CNT_LOAD;
                        acc_hi    <= '0;
                        acc_lo    <= a_load_c;
                        divisor_q <= b_load_c;
                        op_q      <= mul0_div1_sel;
                        div0_q    <= (mul0_div1_sel == OP_DIV) && (opb == '0);
`ifdef MULDIV_SIGNED_EN
                        neg_lo_q  <= neg_lo_c;
                        neg_hi_q  <= neg_hi_c;
`endif
                    end
                end
                RUN: begin
                    acc_hi <= step_hi_c;
                    acc_lo <= step_lo_c;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
`ifdef MULDIV_SIGNED_EN
                FIX: begin
                    if (op_q == OP_MUL) begin
                        {acc_hi, acc_lo} <= -{acc_hi, acc_lo};
                    end else begin
                        if (neg_lo_q) acc_lo <= -acc_lo;
                        if (neg_hi_q) acc_hi <= -acc_hi;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
